// File: rtl/inv_key_schedule.sv
// inv_key_schedule: inverse AES-128 key expansion, emits round keys 10 down to 0 on a valid/ready stream.
// Build option: define INV_KEY_SERIAL_SBOX_EN for one shared S-box (5 cycles per key) instead of four.
//
// state | meaning
// IDLE  | waiting for start; rk_out keeps the last key produced
// EMIT  | rk_out/rk_round valid, waiting for the consumer handshake
// CALC0 | serial build: substitute byte b1 of w3'
// CALC1 | serial build: substitute byte b2 of w3'
// CALC2 | serial build: substitute byte b3 of w3'
// CALC3 | serial build: substitute byte b0 of w3', finish w0', present next key
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_last,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {IDLE, EMIT, CALC0, CALC1, CALC2, CALC3} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  // Rcon walked backwards: 1b is the reduced successor of 80.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

  state_t       state;
  logic [127:0] key_q;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w1n, w2n, w3n;
  logic         hs;

  assign {w0, w1, w2, w3} = key_q;
  assign w3n    = w3 ^ w2;
  assign w2n    = w2 ^ w1;
  assign w1n    = w1 ^ w0;
  assign hs     = rk_valid && rk_ready;
  assign rk_out = key_q;

`ifdef INV_KEY_SERIAL_SBOX_EN
  logic [23:0] sub_q;
  logic [7:0]  sb_in;
  logic [7:0]  sb_out;

  // w3' already sits in key_q[31:0] while the CALC states run.
  always_comb begin
    sb_in = key_q[31:24];
    case (state)
      CALC0:   sb_in = key_q[23:16];
      CALC1:   sb_in = key_q[15:8];
      CALC2:   sb_in = key_q[7:0];
      default: sb_in = key_q[31:24];
    endcase
  end

  assign sb_out = sbox(sb_in);
`else
  logic [31:0] sub_w;
  logic [31:0] w0n;

  assign sub_w = {sbox(w3n[23:16]), sbox(w3n[15:8]), sbox(w3n[7:0]), sbox(w3n[31:24])};
  assign w0n   = w0 ^ sub_w ^ {rcon, 24'h0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_q    <= '0;
      rcon     <= 8'h00;
      rk_round <= 4'd0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
`ifdef INV_KEY_SERIAL_SBOX_EN
      sub_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q    <= key_last;
            rk_round <= 4'd10;
            rcon     <= 8'h36;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
            if (rk_round == 4'd0) begin
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
`ifdef INV_KEY_SERIAL_SBOX_EN
              key_q    <= {w0, w1n, w2n, w3n};
              rk_valid <= 1'b0;
              state    <= CALC0;
`else
              key_q    <= {w0n, w1n, w2n, w3n};
              rk_round <= rk_round - 4'd1;
              rcon     <= inv_xtime(rcon);
`endif
            end
          end
        end
`ifdef INV_KEY_SERIAL_SBOX_EN
        CALC0: begin
          sub_q[23:16] <= sb_out;
          state        <= CALC1;
        end
        CALC1: begin
          sub_q[15:8] <= sb_out;
          state       <= CALC2;
        end
        CALC2: begin
          sub_q[7:0] <= sb_out;
          state      <= CALC3;
        end
        CALC3: begin
          key_q[127:96] <= key_q[127:96] ^ {sub_q, sb_out} ^ {rcon, 24'h0};
          rk_round      <= rk_round - 4'd1;
          rcon          <= inv_xtime(rcon);
          rk_valid      <= 1'b1;
          state         <= EMIT;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
